i2c_xfer_ctrl: RTL and testbench
================================

Name: i2c_xfer_ctrl

Overview:
Transaction sequencer directly upstream of the I2C multi-byte master. It holds a host-loaded TX byte buffer and an RX byte buffer, launches one master transaction per host command, and streams write bytes on the master's new-data requests. It captures read bytes on the master's data-valid pulses, and reports completion, byte count and an error code (NACK/short transfer, launch timeout, bad length). It runs on the same clock as the master.

Parameters:
DEPTH, 16, buffer depth in bytes; must be a power of 2 and at most 65535.
AW, 4, buffer address width; equals log2(DEPTH).
LAUNCH_TO, 255, clock_i cycles allowed between enable and the master's busy rising (8-bit counter).

Ports:
clock_i  in  1  clock, shared with the master.
reset_i  in  1  asynchronous, active-high reset.
start_i  in  1  command strobe; sampled only in IDLE.
rw_i  in  1  1 = read, 0 = write.
ur_i  in  1  use register address.
devadr_i  in  7  device address.
regadr_i  in  8  register address.
len_i  in  AW+1  byte count; valid range 1..DEPTH.
tx_we_i  in  1  TX buffer write enable; honoured only in IDLE.
tx_addr_i  in  AW  TX buffer write address.
tx_data_i  in  8  TX buffer write data.
rx_addr_i  in  AW  RX buffer read address.
rx_data_o  out  8  RX buffer data; registered, 1-cycle read latency.
busy_o  out  1  high from accepted start until done_o.
done_o  out  1  one-cycle completion pulse.
err_o  out  2  0 = OK, 1 = NACK/short, 2 = launch timeout, 3 = bad length; held until next start.
xfer_cnt_o  out  AW+1  bytes actually transferred; held until next start.
m_enable_o  out  1  to master enable_i.
m_rw_o, m_ur_o  out  1 each  to master rw_i, ur_i; registered copies of the command.
m_devadr_o  out  7  to master devadr_i.
m_regadr_o  out  8  to master regadr_i.
m_datnum_o  out  16  to master datnum_i; len zero-extended.
m_dat_o  out  8  to master dat_i.
m_dat_i  in  8  from master dat_o.
m_busy_i, m_dvalid_i, m_newdat_i  in  1 each  from the master.

Behaviour:
- Reset (async) values: state IDLE; busy_o, done_o, m_enable_o = 0; err_o = 0; xfer_cnt_o = 0; m_* command outputs = 0; m_dat_o = 0; ptr = 0; timeout counter = 0. Buffer contents are not reset.
- States: IDLE, CHECK, LAUNCH, RUN, FINISH.
- IDLE:
  - tx_we_i writes tx_mem[tx_addr_i].
  - On start_i: latch rw, ur, devadr, regadr and len into the m_* registers; clear ptr, xfer_cnt_o and err_o; set busy_o; go to CHECK.
- CHECK (1 cycle):
  - len == 0 or len > DEPTH: err_o = 3, go to FINISH; the master is never enabled.
  - Otherwise: m_dat_o <= tx_mem[0], go to LAUNCH.
- LAUNCH:
  - m_enable_o = 1; timeout counter increments.
  - m_busy_i == 1: drop m_enable_o, go to RUN.
  - Counter reaches LAUNCH_TO: drop m_enable_o, err_o = 2, go to FINISH.
- RUN:
  - Write: each m_newdat_i pulse does ptr++ and xfer_cnt++, and m_dat_o <= tx_mem[ptr+1]. The next byte is stable at least 2 cycles before the master latches it. Reads past len-1 wrap modulo DEPTH and are harmless.
  - Read: each m_dvalid_i pulse writes rx_mem[ptr] <= m_dat_i, then ptr++ and xfer_cnt++.
  - Simultaneous newdat and dvalid cannot occur; if it does, the rw-selected pulse wins.
  - m_busy_i falling goes to FINISH. If xfer_cnt < len at that point, err_o = 1: the master returns to idle on NACK without a stop.
- FINISH (1 cycle): done_o = 1, busy_o = 0 at the next edge, return to IDLE. start_i asserted in the FINISH cycle is ignored.
- Latency: start_i to m_enable_o is 2 cycles (IDLE, then CHECK).
- Host writes to the TX buffer while busy_o is high are dropped. rx_data_o is readable at any time; reading an address mid-transfer returns stale or new data without hazard.
- reset_i mid-transfer: the block returns to IDLE immediately and m_enable_o drops. The master must share the reset.

Decomposition:
- Shared package i2c_pkg: error-code constants (ERR_OK, ERR_NACK, ERR_TIMEOUT, ERR_LEN) and state encodings.
- One natural sub-module, i2c_xfer_buf: simple dual-port 8-bit RAM, synchronous write and registered read. Instantiated twice, once for TX and once for RX.

Test Plan:
- Load TX = {A5, 3C, 7E}, then start write (devadr 50, regadr 10, ur = 1, len 3) with a slave model ACKing everything -> SDA carries A0, 10, A5, 3C, 7E then stop; done_o pulse; err_o = 0; xfer_cnt_o = 3.
- Start read with len 4 while the slave returns 11, 22, 33, 44 -> rx_mem[0..3] = 11, 22, 33, 44; last byte NACKed by the master; err_o = 0; xfer_cnt_o = 4.
- Slave NACKs the second data byte of a len 4 write -> master idles early; err_o = 1; xfer_cnt_o = 2; done_o pulses once.
- len 0, then len DEPTH+1 -> m_enable_o never asserts; err_o = 3; done_o pulses 2 cycles after start_i.
- m_busy_i held low (master stub) -> m_enable_o drops after 255 cycles; err_o = 2.
- Assert reset_i mid-read, then restart a len 1 read -> outputs return to reset values immediately; second transfer completes with err_o = 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer: FSM states and error codes.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LAUNCH,
        ST_RUN,
        ST_FINISH
    } xfer_state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_LEN     = 2'd3;

endpackage

// File: rtl/i2c_xfer_buf.sv
// Simple dual-port byte RAM: synchronous write, registered read with read enable.
module i2c_xfer_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Storage itself is never reset; only the read register has a defined reset value.
    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/i2c_xfer_ctrl.sv
// Transaction sequencer in front of the I2C multi-byte master: buffers TX/RX bytes,
// launches one master transfer per command and reports status.
module i2c_xfer_ctrl
    import i2c_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int LAUNCH_TO = 255
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          rw_i,
    input  logic          ur_i,
    input  logic [6:0]    devadr_i,
    input  logic [7:0]    regadr_i,
    input  logic [AW:0]   len_i,
    input  logic          tx_we_i,
    input  logic [AW-1:0] tx_addr_i,
    input  logic [7:0]    tx_data_i,
    input  logic [AW-1:0] rx_addr_i,
    output logic [7:0]    rx_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    err_o,
    output logic [AW:0]   xfer_cnt_o,
    output logic          m_enable_o,
    output logic          m_rw_o,
    output logic          m_ur_o,
    output logic [6:0]    m_devadr_o,
    output logic [7:0]    m_regadr_o,
    output logic [15:0]   m_datnum_o,
    output logic [7:0]    m_dat_o,
    input  logic [7:0]    m_dat_i,
    input  logic          m_busy_i,
    input  logic          m_dvalid_i,
    input  logic          m_newdat_i
);

    xfer_state_t   state, state_nxt;
    logic [AW:0]   len_q;
    logic [AW-1:0] ptr;
    logic [7:0]    to_cnt;
    logic          len_bad, to_hit, wr_pulse, rd_pulse, step;
    logic [AW:0]   cnt_step;
    logic          tx_rd_en;
    logic [AW-1:0] tx_rd_addr;

    assign len_bad  = (len_q == '0) || (len_q > (AW+1)'(DEPTH));
    assign to_hit   = (to_cnt == 8'(LAUNCH_TO - 1));
    // Only the pulse matching the command direction counts as a byte.
    assign wr_pulse = (state == ST_RUN) && !m_rw_o && m_newdat_i;
    assign rd_pulse = (state == ST_RUN) &&  m_rw_o && m_dvalid_i;
    assign step     = wr_pulse | rd_pulse;
    assign cnt_step = xfer_cnt_o + {{AW{1'b0}}, step};

    assign m_datnum_o = 16'(len_q);

    // The TX read register doubles as m_dat_o: byte 0 is fetched in CHECK, the next byte on each newdat.
    assign tx_rd_en   = ((state == ST_CHECK) && !len_bad) || wr_pulse;
    assign tx_rd_addr = (state == ST_CHECK) ? '0 : ptr + AW'(1);

    i2c_xfer_buf #(.DEPTH(DEPTH), .AW(AW)) u_tx_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (tx_we_i && (state == ST_IDLE)),
        .wr_addr (tx_addr_i),
        .wr_data (tx_data_i),
        .rd_en   (tx_rd_en),
        .rd_addr (tx_rd_addr),
        .rd_data (m_dat_o)
    );

    i2c_xfer_buf #(.DEPTH(DEPTH), .AW(AW)) u_rx_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .wr_en   (rd_pulse),
        .wr_addr (ptr),
        .wr_data (m_dat_i),
        .rd_en   (1'b1),
        .rd_addr (rx_addr_i),
        .rd_data (rx_data_o)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy_o     = (state != ST_IDLE);
        done_o     = (state == ST_FINISH);
        m_enable_o = (state == ST_LAUNCH);
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = len_bad ? ST_FINISH : ST_LAUNCH;
            ST_LAUNCH: begin
                if (m_busy_i) begin
                    state_nxt = ST_RUN;
                end else if (to_hit) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_RUN:    if (!m_busy_i) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            err_o      <= ERR_OK;
            xfer_cnt_o <= '0;
            m_rw_o     <= 1'b0;
            m_ur_o     <= 1'b0;
            m_devadr_o <= '0;
            m_regadr_o <= '0;
            len_q      <= '0;
            ptr        <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        m_rw_o     <= rw_i;
                        m_ur_o     <= ur_i;
                        m_devadr_o <= devadr_i;
                        m_regadr_o <= regadr_i;
                        len_q      <= len_i;
                        ptr        <= '0;
                        xfer_cnt_o <= '0;
                        err_o      <= ERR_OK;
                        to_cnt     <= '0;
                    end
                end
                ST_CHECK: begin
                    if (len_bad) err_o <= ERR_LEN;
                end
                ST_LAUNCH: begin
                    to_cnt <= to_cnt + 8'd1;
                    if (!m_busy_i && to_hit) err_o <= ERR_TIMEOUT;
                end
                ST_RUN: begin
                    if (step) begin
                        ptr        <= ptr + AW'(1);
                        xfer_cnt_o <= cnt_step;
                    end
                    // Master dropping busy before all bytes moved means it gave up on a NACK.
                    if (!m_busy_i && (cnt_step < len_q)) err_o <= ERR_NACK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Self-checking bench for i2c_xfer_ctrl: a master stub plus a transaction-level reference model.
module tb_i2c_xfer_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          start_i = 1'b0, rw_i = 1'b0, ur_i = 1'b0;
    logic [6:0]    devadr_i = '0;
    logic [7:0]    regadr_i = '0;
    logic [AW:0]   len_i = '0;
    logic          tx_we_i = 1'b0;
    logic [AW-1:0] tx_addr_i = '0, rx_addr_i = '0;
    logic [7:0]    tx_data_i = '0, rx_data_o;
    logic          busy_o, done_o, m_enable_o, m_rw_o, m_ur_o;
    logic [1:0]    err_o;
    logic [AW:0]   xfer_cnt_o;
    logic [6:0]    m_devadr_o;
    logic [7:0]    m_regadr_o, m_dat_o;
    logic [15:0]   m_datnum_o;
    logic [7:0]    m_dat_i = '0;
    logic          m_busy_i = 1'b0, m_dvalid_i = 1'b0, m_newdat_i = 1'b0;

    always #5 clock_i = ~clock_i;

    i2c_xfer_ctrl #(.DEPTH(DEPTH), .AW(AW), .LAUNCH_TO(255)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .rw_i(rw_i), .ur_i(ur_i),
        .devadr_i(devadr_i), .regadr_i(regadr_i), .len_i(len_i),
        .tx_we_i(tx_we_i), .tx_addr_i(tx_addr_i), .tx_data_i(tx_data_i),
        .rx_addr_i(rx_addr_i), .rx_data_o(rx_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .xfer_cnt_o(xfer_cnt_o),
        .m_enable_o(m_enable_o), .m_rw_o(m_rw_o), .m_ur_o(m_ur_o),
        .m_devadr_o(m_devadr_o), .m_regadr_o(m_regadr_o), .m_datnum_o(m_datnum_o),
        .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_busy_i(m_busy_i),
        .m_dvalid_i(m_dvalid_i), .m_newdat_i(m_newdat_i)
    );

    logic [7:0]  tx_model [DEPTH];
    logic [7:0]  rx_model [DEPTH];
    logic [1:0]  exp_err = '0, held_err = '0;
    logic [AW:0] exp_cnt = '0, held_cnt = '0, exp_len = '0;
    int          done_seen = 0;
    int          checks = 0, errors = 0;
    bit          fixed_rx = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Status outputs: checked each cycle against what the model says the last command produced.
    always @(negedge clock_i) begin
        if (reset_i) begin
            held_err = '0;
            held_cnt = '0;
        end else begin
            checkOutput("enable_without_busy", {63'd0, m_enable_o && !busy_o}, 64'd0);
            if (done_o) begin
                checkOutput("done_err", err_o, exp_err);
                checkOutput("done_cnt", xfer_cnt_o, exp_cnt);
                held_err = exp_err;
                held_cnt = exp_cnt;
                done_seen++;
            end else if (!busy_o) begin
                checkOutput("held_err", err_o, held_err);
                checkOutput("held_cnt", xfer_cnt_o, held_cnt);
            end
            if (busy_o) checkOutput("datnum", m_datnum_o, 16'(exp_len));
        end
    end

    task automatic writeTx(input int addr, input logic [7:0] data);
        tx_we_i   = 1'b1;
        tx_addr_i = AW'(addr);
        tx_data_i = data;
        tick();
        tx_we_i   = 1'b0;
        tx_model[addr] = data;
    endtask

    task automatic waitDone(input int start_done);
        int budget;
        budget = 0;
        while (done_seen == start_done && budget < 40) begin
            tick();
            budget++;
        end
        tick();
        checkOutput("done_pulses", done_seen - start_done, 1);
        checkOutput("idle_after_done", busy_o, 0);
    endtask

    // One host command with the master stub acting on the DUT's handshake.
    task automatic applyStimulus(input logic rw, input logic ur, input logic [6:0] dev,
                                 input logic [7:0] rga, input int len, input int nack_at,
                                 input bit stall);
        int nbytes, d, start_done, en_cycles;
        logic [7:0] b;
        bit bad;
        bad    = (len == 0) || (len > DEPTH);
        nbytes = (bad || stall) ? 0 : (rw ? len : ((nack_at >= 0) ? nack_at + 1 : len));
        exp_len = (AW+1)'(len);
        exp_cnt = (AW+1)'(nbytes);
        exp_err = bad ? 2'd3 : stall ? 2'd2 : (nbytes < len) ? 2'd1 : 2'd0;
        start_done = done_seen;
        rw_i = rw; ur_i = ur; devadr_i = dev; regadr_i = rga; len_i = (AW+1)'(len);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checkOutput("cmd_regs", {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o}, {rw, ur, dev, rga});
        checkOutput("check_cleared", {err_o, xfer_cnt_o, m_enable_o}, 0);
        if (bad) begin
            start_i = 1'b1;
            tick();
            checkOutput("bad_len_done", {done_o, m_enable_o}, 2'b10);
            tick();
            start_i = 1'b0;
            checkOutput("finish_ignores_start", busy_o, 0);
        end else begin
            tick();
            checkOutput("enable_latency", m_enable_o, 1);
            if (stall) begin
                en_cycles = 0;
                while (m_enable_o && en_cycles < 400) begin
                    en_cycles++;
                    tick();
                end
                checkOutput("timeout_cycles", en_cycles, 255);
            end else begin
                d = $urandom_range(0, 4);
                repeat (d) begin
                    tx_we_i   = 1'b1;
                    tx_addr_i = AW'($urandom);
                    tx_data_i = 8'($urandom);
                    tick();
                    tx_we_i   = 1'b0;
                end
                checkOutput("enable_hold", m_enable_o, 1);
                m_busy_i = 1'b1;
                tick();
                checkOutput("enable_drop", m_enable_o, 0);
                for (int i = 0; i < nbytes; i++) begin
                    repeat ($urandom_range(2, 4)) tick();
                    if (rw) begin
                        b = fixed_rx ? 8'((i + 1) * 17) : 8'($urandom);
                        rx_model[i % DEPTH] = b;
                        m_dat_i    = b;
                        m_dvalid_i = 1'b1;
                        tick();
                        m_dvalid_i = 1'b0;
                    end else begin
                        checkOutput("wr_byte", m_dat_o, tx_model[i]);
                        m_newdat_i = 1'b1;
                        tick();
                        m_newdat_i = 1'b0;
                    end
                end
                if (!rw) checkOutput("dat_next", m_dat_o, tx_model[nbytes % DEPTH]);
                repeat (2) tick();
                m_busy_i = 1'b0;
            end
        end
        waitDone(start_done);
        if (rw && !bad && !stall) begin
            for (int i = 0; i < nbytes; i++) begin
                rx_addr_i = AW'(i);
                tick();
                checkOutput("rx_data", rx_data_o, rx_model[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d checks done", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int len, nack;
        reset_i = 1'b1;
        repeat (3) tick();
        checkOutput("reset_status", {busy_o, done_o, m_enable_o, err_o, xfer_cnt_o}, 0);
        checkOutput("reset_cmd", {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o, m_dat_o}, 0);
        reset_i = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) writeTx(i, 8'($urandom));
        writeTx(0, 8'hA5);
        writeTx(1, 8'h3C);
        writeTx(2, 8'h7E);

        $display("[TB] write len 3");
        applyStimulus(1'b0, 1'b1, 7'h50, 8'h10, 3, -1, 1'b0);
        checkOutput("wr3_lit", {err_o, xfer_cnt_o}, {2'd0, 5'd3});

        $display("[TB] read len 4");
        fixed_rx = 1'b1;
        applyStimulus(1'b1, 1'b1, 7'h50, 8'h10, 4, -1, 1'b0);
        fixed_rx = 1'b0;
        rx_addr_i = 2;
        tick();
        checkOutput("rx_lit", rx_data_o, 8'h33);
        checkOutput("rd4_lit", {err_o, xfer_cnt_o}, {2'd0, 5'd4});

        $display("[TB] NACK on second byte");
        applyStimulus(1'b0, 1'b0, 7'h22, 8'h00, 4, 1, 1'b0);
        checkOutput("nack_lit", {err_o, xfer_cnt_o}, {2'd1, 5'd2});

        $display("[TB] bad lengths");
        applyStimulus(1'b0, 1'b0, 7'h11, 8'h01, 0, -1, 1'b0);
        applyStimulus(1'b1, 1'b0, 7'h11, 8'h01, DEPTH + 1, -1, 1'b0);
        checkOutput("badlen_lit", err_o, 2'd3);

        $display("[TB] launch timeout");
        applyStimulus(1'b0, 1'b1, 7'h33, 8'h44, 2, -1, 1'b1);
        checkOutput("timeout_lit", {err_o, xfer_cnt_o}, {2'd2, 5'd0});

        $display("[TB] reset mid-read");
        exp_len = 5'd4;
        rw_i = 1'b1; len_i = 5'd4; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        m_busy_i = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            repeat (2) tick();
            m_dat_i = 8'($urandom);
            rx_model[i] = m_dat_i;
            m_dvalid_i = 1'b1;
            tick();
            m_dvalid_i = 1'b0;
        end
        reset_i = 1'b1;
        #1;
        checkOutput("async_reset_status", {busy_o, done_o, m_enable_o, err_o, xfer_cnt_o}, 0);
        checkOutput("async_reset_cmd", {m_rw_o, m_datnum_o, m_dat_o}, 0);
        m_busy_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 7'h50, 8'h00, 1, -1, 1'b0);
        checkOutput("restart_lit", {err_o, xfer_cnt_o}, {2'd0, 5'd1});

        $display("[TB] randomized transactions");
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) writeTx($urandom_range(0, DEPTH - 1), 8'($urandom));
            end
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
                default: len = $urandom_range(1, DEPTH);
            endcase
            nack = -1;
            if (len >= 1 && len <= DEPTH && $urandom_range(0, 3) == 0) nack = $urandom_range(0, len - 1);
            applyStimulus(1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom), len, nack, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
